// File: rtl/mannix_rd_arb.sv
// rtl/mannix_rd_arb.sv - priority/round-robin read arbiter with one outstanding memory read
module mannix_rd_arb #(
    parameter int N_CLI      = 5,
    parameter int ADDR_WIDTH = 19,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CLI-1:0]            cli_req,
    input  logic [N_CLI*ADDR_WIDTH-1:0] cli_addr,
    input  logic [N_CLI-1:0]            client_priority,
    output logic [N_CLI-1:0]            cli_gnt,
    output logic [N_CLI-1:0]            cli_done,
    output logic                        cli_err,
    output logic                        mem_req,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic                        mem_accept,
    input  logic                        mem_rvalid,
    output logic                        timeout_sticky
);

    localparam int IW = (N_CLI > 1) ? $clog2(N_CLI) : 1;
    // The abort is decided one cycle before the counter would reach TIMEOUT,
    // so the registered cli_done lands exactly TIMEOUT cycles after WAIT entry.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IW-1:0]           last_gnt;
    logic [7:0]              wcnt;
    logic [N_CLI-1:0]        cand;
    logic [IW-1:0]           win;
    logic [N_CLI-1:0]        win_oh;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic                    found;
    logic [IW-1:0]           probe;
    logic                    grab;
    logic                    fin_ok;
    logic                    fin_to;

    assign mem_req = (state == S_ISSUE);

    // Winner selection: high class first, then rotate upward from last winner.
    always_comb begin
        cand     = ((cli_req & client_priority) != '0) ? (cli_req & client_priority) : cli_req;
        found    = 1'b0;
        win      = '0;
        probe    = '0;
        win_oh   = '0;
        win_addr = '0;
        for (int k = 1; k <= N_CLI; k++) begin
            probe = IW'((int'(last_gnt) + k) % N_CLI);
            if (!found && cand[probe]) begin
                found = 1'b1;
                win   = probe;
            end
        end
        for (int i = 0; i < N_CLI; i++) begin
            if (IW'(i) == win) begin
                win_oh[i] = 1'b1;
                win_addr  = cli_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Next-state logic and transaction events.
    always_comb begin
        state_nxt = state;
        grab      = 1'b0;
        fin_ok    = 1'b0;
        fin_to    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cli_req != '0) begin
                    grab      = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_accept) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    fin_ok    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wcnt == TO_LAST) begin
                    fin_to    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Grant, address, wait counter and completion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cli_gnt        <= '0;
            cli_done       <= '0;
            cli_err        <= 1'b0;
            mem_addr       <= '0;
            timeout_sticky <= 1'b0;
            wcnt           <= '0;
            last_gnt       <= IW'(N_CLI - 1);
        end else begin
            cli_done <= '0;
            cli_err  <= 1'b0;
            if (grab) begin
                cli_gnt  <= win_oh;
                mem_addr <= win_addr;
                last_gnt <= win;
            end
            if (state == S_ISSUE && mem_accept) wcnt <= '0;
            else if (state == S_WAIT)           wcnt <= wcnt + 8'd1;
            if (fin_ok || fin_to) begin
                cli_done <= cli_gnt;
                cli_err  <= fin_to;
                cli_gnt  <= '0;
            end
            if (fin_to) timeout_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mannix_rd_arb.sv
// tb/tb_mannix_rd_arb.sv - directed table-driven bench for mannix_rd_arb
module tb_mannix_rd_arb;

    localparam int N  = 5;
    localparam int AW = 19;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    cli_req = '0;
    logic [N*AW-1:0] cli_addr;
    logic [N-1:0]    client_priority = '0;
    logic [N-1:0]    cli_gnt;
    logic [N-1:0]    cli_done;
    logic            cli_err;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_accept = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic            timeout_sticky;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] prio;
        logic [N-1:0] gnt;
        int           lat;
        bit           drop;
    } vec_t;

    vec_t tbl [13];

    mannix_rd_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cli_req        (cli_req),
        .cli_addr       (cli_addr),
        .client_priority(client_priority),
        .cli_gnt        (cli_gnt),
        .cli_done       (cli_done),
        .cli_err        (cli_err),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_accept     (mem_accept),
        .mem_rvalid     (mem_rvalid),
        .timeout_sticky (timeout_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(i * 32'h1234 + 32'h00a5);
    endfunction

    function automatic int idx_of(input logic [N-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic set_addrs(input logic [AW-1:0] flip);
        for (int i = 0; i < N; i++) cli_addr[i*AW +: AW] = addr_of(i) ^ flip;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_txn(input vec_t v);
        logic [AW-1:0] ea;
        ea = addr_of(idx_of(v.gnt));
        cli_req = v.req;
        client_priority = v.prio;
        @(posedge clk); #1;
        chk("gnt", 32'(cli_gnt), 32'(v.gnt));
        chk("issue_req", 32'(mem_req), 32'd1);
        chk("addr", 32'(mem_addr), 32'(ea));
        set_addrs('1);
        client_priority = ~v.prio;
        mem_accept = 1'b1;
        @(posedge clk); #1;
        mem_accept = 1'b0;
        chk("wait_req", 32'(mem_req), 32'd0);
        chk("addr_hold", 32'(mem_addr), 32'(ea));
        chk("gnt_hold", 32'(cli_gnt), 32'(v.gnt));
        if (v.drop) cli_req = '0;
        repeat (v.lat - 1) begin
            @(posedge clk); #1;
            chk("no_done", 32'(cli_done), 32'd0);
        end
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("done", 32'(cli_done), 32'(v.gnt));
        chk("err", 32'(cli_err), 32'd0);
        chk("gap", 32'(cli_gnt), 32'd0);
        set_addrs('0);
        client_priority = v.prio;
    endtask

    initial begin
        int got;
        tbl[0]  = '{5'b00001, 5'b00000, 5'b00001, 3, 1'b0};
        tbl[1]  = '{5'b11111, 5'b00000, 5'b00010, 1, 1'b0};
        tbl[2]  = '{5'b11111, 5'b00000, 5'b00100, 1, 1'b0};
        tbl[3]  = '{5'b11111, 5'b00000, 5'b01000, 1, 1'b0};
        tbl[4]  = '{5'b11111, 5'b00000, 5'b10000, 1, 1'b0};
        tbl[5]  = '{5'b11111, 5'b00000, 5'b00001, 1, 1'b0};
        tbl[6]  = '{5'b10011, 5'b10000, 5'b10000, 2, 1'b0};
        tbl[7]  = '{5'b10011, 5'b10000, 5'b10000, 2, 1'b1};
        tbl[8]  = '{5'b00011, 5'b10000, 5'b00001, 4, 1'b0};
        tbl[9]  = '{5'b00011, 5'b10000, 5'b00010, 1, 1'b0};
        tbl[10] = '{5'b10100, 5'b00100, 5'b00100, 2, 1'b0};
        tbl[11] = '{5'b11000, 5'b00000, 5'b01000, 3, 1'b0};
        tbl[12] = '{5'b00101, 5'b00001, 5'b00001, 1, 1'b0};

        set_addrs('0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(cli_gnt), 32'd0);
        chk("rst_done", 32'(cli_done), 32'd0);
        chk("rst_err", 32'(cli_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_sticky", 32'(timeout_sticky), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_gnt", 32'(cli_gnt), 32'd0);
        chk("idle_mem_req", 32'(mem_req), 32'd0);

        for (int i = 0; i < 13; i++) do_txn(tbl[i]);

        // Client 2 never sees rvalid; rvalid in ISSUE must be ignored.
        cli_req = 5'b00100;
        client_priority = '0;
        @(posedge clk); #1;
        chk("to_gnt", 32'(cli_gnt), 32'b00100);
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("issue_rvalid_done", 32'(cli_done), 32'd0);
        chk("issue_rvalid_req", 32'(mem_req), 32'd1);
        mem_accept = 1'b1;
        @(posedge clk); #1;
        mem_accept = 1'b0;
        cli_req = '0;
        got = 0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (cli_done != '0) begin
                got = n;
                break;
            end
        end
        chk("to_cycles", 32'(got), 32'd255);
        chk("to_done", 32'(cli_done), 32'b00100);
        chk("to_err", 32'(cli_err), 32'd1);
        chk("to_sticky", 32'(timeout_sticky), 32'd1);
        @(posedge clk); #1;
        chk("to_pulse", 32'(cli_done), 32'd0);
        chk("to_sticky_hold", 32'(timeout_sticky), 32'd1);

        // Reset clears sticky; rvalid coincides with the timeout cycle.
        rst_n = 1'b0;
        #1;
        chk("rst2_sticky", 32'(timeout_sticky), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cli_req = 5'b11111;
        @(posedge clk); #1;
        chk("rst2_first_gnt", 32'(cli_gnt), 32'b00001);
        mem_accept = 1'b1;
        @(posedge clk); #1;
        mem_accept = 1'b0;
        repeat (254) @(posedge clk);
        #1;
        chk("tie_no_done", 32'(cli_done), 32'd0);
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        cli_req = '0;
        chk("tie_done", 32'(cli_done), 32'b00001);
        chk("tie_err", 32'(cli_err), 32'd0);
        chk("tie_sticky", 32'(timeout_sticky), 32'd0);

        // Reset during WAIT of client 3.
        @(posedge clk); #1;
        cli_req = 5'b01000;
        @(posedge clk); #1;
        chk("c3_gnt", 32'(cli_gnt), 32'b01000);
        mem_accept = 1'b1;
        @(posedge clk); #1;
        mem_accept = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(cli_gnt), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_done", 32'(cli_done), 32'd0);
        chk("mid_rst_err", 32'(cli_err), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_done2", 32'(cli_done), 32'd0);
        rst_n = 1'b1;
        do_txn('{5'b01000, 5'b00000, 5'b01000, 2, 1'b0});
        cli_req = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("end_idle", 32'(cli_gnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
